// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bus between the requesters and the round-robin mux arbiter.
// The master side drives requests and data; the slave side is the arbiter.
interface mux_rr_arbiter_if #(
    parameter int unsigned N    = 8,
    parameter int unsigned W    = 4,
    parameter int unsigned SELW = 3
);
    logic [N-1:0]    req;
    logic [N*W-1:0]  data_in;
    logic [N-1:0]    gnt;
    logic [SELW-1:0] sel;
    logic            valid;
    logic [W-1:0]    yout;

    modport master (
        output req,
        output data_in,
        input  gnt,
        input  sel,
        input  valid,
        input  yout
    );

    modport slave (
        input  req,
        input  data_in,
        output gnt,
        output sel,
        output valid,
        output yout
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter in front of an 8:1 mux. Grants one requester at a time
// for at most MAX_HOLD consecutive cycles, drives the registered select and
// forwards the granted data word combinationally.
module mux_rr_arbiter #(
    parameter int unsigned N        = 8,
    parameter int unsigned W        = 4,
    parameter int unsigned SELW     = 3,
    parameter int unsigned MAX_HOLD = 4
) (
    input logic              clk,
    input logic              rst,
    mux_rr_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e          r_state;
    logic [SELW-1:0] r_ptr;
    logic [3:0]      r_hold_cnt;
    logic [N-1:0]    r_gnt;
    logic [SELW-1:0] r_sel;
    logic            r_valid;

    logic [SELW-1:0] w_start;
    logic            w_found;
    logic [SELW-1:0] w_pick;
    logic [N-1:0]    w_pick_oh;
    logic            w_keep;
    logic [W-1:0]    w_yout;

    // Search start: the saved pointer when idle, the index after the holder when granting.
    always_comb begin
        w_start = r_ptr;
        if (r_state == StGrant) begin
            w_start = (r_sel == SELW'(N - 1)) ? '0 : r_sel + 1'b1;
        end
    end

    // First active request at or after w_start, wrapping modulo N.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && bus.req[(int'(w_start) + k) % N]) begin
                w_found = 1'b1;
                w_pick  = SELW'((int'(w_start) + k) % N);
            end
        end
        w_pick_oh = {{(N - 1){1'b0}}, 1'b1} << w_pick;
    end

    // Holder keeps the channel while it still requests and has budget left.
    always_comb begin
        w_keep = bus.req[r_sel] && (r_hold_cnt < 4'(MAX_HOLD - 1));
    end

    // Grant FSM with registered grant, select and valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_gnt      <= '0;
            r_sel      <= '0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_gnt      <= w_pick_oh;
                        r_sel      <= w_pick;
                        r_valid    <= 1'b1;
                        r_hold_cnt <= '0;
                        r_state    <= StGrant;
                    end
                end
                StGrant: begin
                    if (w_keep) begin
                        r_hold_cnt <= r_hold_cnt + 4'd1;
                    end else begin
                        r_ptr      <= w_start;
                        r_hold_cnt <= '0;
                        if (w_found) begin
                            // Lone requester on expiry wraps back to itself: grant stays high.
                            r_gnt <= w_pick_oh;
                            r_sel <= w_pick;
                        end else begin
                            // sel deliberately keeps its last value.
                            r_gnt   <= '0;
                            r_valid <= 1'b0;
                            r_state <= StIdle;
                        end
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Forward the granted word; zero when nothing is granted.
    always_comb begin
        w_yout = '0;
        if (r_valid) begin
            w_yout = bus.data_in[int'(r_sel) * W +: W];
        end
    end

    assign bus.gnt   = r_gnt;
    assign bus.sel   = r_sel;
    assign bus.valid = r_valid;
    assign bus.yout  = w_yout;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed, table-driven bench for mux_rr_arbiter (N=8, W=4, MAX_HOLD=4).
module tb_mux_rr_arbiter;

    typedef struct {
        logic        rst;
        logic [7:0]  req;
        logic [31:0] data;
        logic [7:0]  gnt;
        logic [2:0]  sel;
        logic        valid;
        logic [3:0]  yout;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    mux_rr_arbiter_if #(.N(8), .W(4), .SELW(3)) bus ();

    mux_rr_arbiter #(.N(8), .W(4), .SELW(3), .MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [7:0] q, input logic [31:0] d,
                       input logic [7:0] g, input logic [2:0] s, input logic v,
                       input logic [3:0] y);
        vec_t e;
        e.rst = r; e.req = q; e.data = d;
        e.gnt = g; e.sel = s; e.valid = v; e.yout = y;
        vecs.push_back(e);
    endtask

    initial begin
        logic [31:0] dseq;
        logic [7:0]  g;
        n_checks = 0;
        n_fail   = 0;
        rst         = 1'b1;
        bus.req     = '0;
        bus.data_in = '0;
        dseq        = 32'h7654_3210;

        // Reset with all requesting, then fairness: 4 cycles each in order 0..7, back to 0.
        add(1, 8'hFF, dseq, 8'h00, 0, 0, 4'h0);
        add(1, 8'hFF, dseq, 8'h00, 0, 0, 4'h0);
        for (int r = 0; r < 8; r++) begin
            g = 8'h01 << r;
            for (int c = 0; c < 4; c++) add(0, 8'hFF, dseq, g, 3'(r), 1, 4'(r));
        end
        add(0, 8'hFF, dseq, 8'h01, 0, 1, 4'h0);
        // Single requester 3, then release.
        add(1, 8'h00, dseq, 8'h00, 0, 0, 4'h0);
        add(0, 8'h08, 32'h0000_1000, 8'h08, 3, 1, 4'h1);
        add(0, 8'h00, 32'h0000_1000, 8'h00, 3, 0, 4'h0);
        // Early release of requester 0 after two cycles hands over to 4.
        add(1, 8'h00, dseq, 8'h00, 0, 0, 4'h0);
        add(0, 8'h11, 32'h0008_0005, 8'h01, 0, 1, 4'h5);
        add(0, 8'h11, 32'h0008_0005, 8'h01, 0, 1, 4'h5);
        add(0, 8'h10, 32'h0008_0005, 8'h10, 4, 1, 4'h8);
        add(0, 8'h00, 32'h0008_0005, 8'h00, 4, 0, 4'h0);
        // Lone requester 7 for 10 cycles; data change mid-grant is forwarded.
        for (int c = 0; c < 10; c++) begin
            if (c == 5) add(0, 8'h80, 32'hA000_0003, 8'h80, 7, 1, 4'hA);
            else        add(0, 8'h80, 32'h9000_0003, 8'h80, 7, 1, 4'h9);
        end
        // Requester 0 joins: granted once 7 expires (hold count 1 -> 2 -> 3 -> expiry).
        add(0, 8'h81, 32'h9000_0003, 8'h80, 7, 1, 4'h9);
        add(0, 8'h81, 32'h9000_0003, 8'h80, 7, 1, 4'h9);
        add(0, 8'h81, 32'h9000_0003, 8'h01, 0, 1, 4'h3);
        // Reach gnt=04, reset mid-grant, then pointer restarts at 0.
        add(0, 8'h04, dseq, 8'h04, 2, 1, 4'h2);
        add(1, 8'h04, dseq, 8'h00, 0, 0, 4'h0);
        add(0, 8'h06, dseq, 8'h02, 1, 1, 4'h1);
        // Holder 1 drops as 3 rises in the same cycle; 2 dropped before being granted.
        add(0, 8'h08, dseq, 8'h08, 3, 1, 4'h3);
        add(0, 8'h00, dseq, 8'h00, 3, 0, 4'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst         = vecs[i].rst;
            bus.req     = vecs[i].req;
            bus.data_in = vecs[i].data;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d gnt", i),   32'(bus.gnt),   32'(vecs[i].gnt));
            chk($sformatf("v%0d sel", i),   32'(bus.sel),   32'(vecs[i].sel));
            chk($sformatf("v%0d valid", i), 32'(bus.valid), 32'(vecs[i].valid));
            chk($sformatf("v%0d yout", i),  32'(bus.yout),  32'(vecs[i].yout));
            chk($sformatf("v%0d gnt[sel]==valid", i),
                32'(bus.gnt[bus.sel]), 32'(bus.valid));
            chk($sformatf("v%0d onehot0", i), 32'($countones(bus.gnt) <= 1), 32'd1);
        end

        // yout follows data_in between edges while the grant is held.
        @(negedge clk);
        bus.req     = 8'h02;
        bus.data_in = dseq;
        @(posedge clk);
        #1;
        chk("comb gnt", 32'(bus.gnt), 32'h02);
        chk("comb yout0", 32'(bus.yout), 32'h1);
        #2;
        bus.data_in = 32'h0000_00F0;
        #1;
        chk("comb yout1", 32'(bus.yout), 32'hF);
        bus.data_in = 32'h0000_0060;
        #1;
        chk("comb yout2", 32'(bus.yout), 32'h6);

        // Reset dominates with requests present; grant lands exactly one cycle after release.
        @(negedge clk);
        rst     = 1'b1;
        bus.req = 8'hFF;
        @(posedge clk);
        #1;
        chk("rst gnt", 32'(bus.gnt), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        chk("pre-edge gnt", 32'(bus.gnt), 32'h00);
        @(posedge clk);
        #1;
        chk("post-rst gnt", 32'(bus.gnt), 32'h01);
        chk("post-rst sel", 32'(bus.sel), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
